// File: rtl/bpu_update_sched.sv
// bpu_update_sched: buffers EX/mispredict BTB updates in a FIFO, drains one per cycle, runs flush invalidate walks.
// Optional BPU_UPD_COALESCE_EN: a request whose pc matches a queued slot rewrites that slot's target.
module bpu_update_sched #(
  parameter int ENTRIES    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  localparam int IDX_W     = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_upd_valid,
  input  logic [ADDR_W-1:0] ex_upd_pc,
  input  logic [ADDR_W-1:0] ex_upd_target,
  output logic              ex_upd_ready,
  input  logic              mis_upd_valid,
  input  logic [ADDR_W-1:0] mis_upd_pc,
  input  logic [ADDR_W-1:0] mis_upd_target,
  output logic              mis_upd_ready,
  input  logic              flush_all,
  output logic [ADDR_W-1:0] probe_pc,
  input  logic              probe_hit,
  input  logic [IDX_W-1:0]  probe_idx,
  input  logic [IDX_W-1:0]  victim_idx,
  input  logic              btb_wr_ready,
  output logic              btb_wr_en,
  output logic [IDX_W-1:0]  btb_wr_idx,
  output logic              btb_wr_valid,
  output logic [ADDR_W-1:0] btb_wr_pc,
  output logic [ADDR_W-1:0] btb_wr_target,
  output logic              busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] tgt_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] walk;
  logic can_acc, enq, run_wr, pop, alloc;
  logic [ADDR_W-1:0] in_pc, in_tgt;
  logic [FIFO_DEPTH-1:0] hit_slot;
  assign can_acc = !reset && state != FLUSH && !flush_all && cnt < CW'(FIFO_DEPTH);
  assign mis_upd_ready = can_acc;
  assign ex_upd_ready = can_acc && !mis_upd_valid;
  assign enq = can_acc && (mis_upd_valid || ex_upd_valid);
  assign in_pc = mis_upd_valid ? mis_upd_pc : ex_upd_pc;
  assign in_tgt = mis_upd_valid ? mis_upd_target : ex_upd_target;
  assign run_wr = !reset && !flush_all && state == RUN && cnt != '0;
  assign pop = run_wr && btb_wr_ready;
`ifdef BPU_UPD_COALESCE_EN
  // the head slot leaving this cycle cannot absorb a request
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_match
    assign hit_slot[i] = ({1'b0, PW'(i) - rd_ptr} < cnt) && pc_q[i] == in_pc
                         && !(pop && PW'(i) == rd_ptr);
  end
`else
  assign hit_slot = '0;
`endif
  assign alloc = enq && hit_slot == '0;
  assign cnt_nxt = cnt + CW'(alloc) - CW'(pop);
  assign btb_wr_en = run_wr || (!reset && !flush_all && state == FLUSH);
  assign btb_wr_valid = run_wr;
  assign btb_wr_idx = run_wr ? (probe_hit ? probe_idx : victim_idx) : (btb_wr_en ? walk : '0);
  assign btb_wr_pc = run_wr ? pc_q[rd_ptr] : '0;
  assign btb_wr_target = run_wr ? tgt_q[rd_ptr] : '0;
  assign probe_pc = (!reset && cnt != '0) ? pc_q[rd_ptr] : '0;
  assign busy = !reset && (cnt != '0 || state == FLUSH);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      walk <= '0;
    end else if (flush_all) begin
      state <= FLUSH;
      cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      walk <= '0;
    end else if (state == FLUSH) begin
      if (btb_wr_ready) begin
        walk <= (walk == IDX_W'(ENTRIES - 1)) ? '0 : walk + 1'b1;
        if (walk == IDX_W'(ENTRIES - 1)) state <= IDLE;
      end
    end else begin
      cnt <= cnt_nxt;
      if (alloc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      state <= (cnt_nxt != '0) ? RUN : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[wr_ptr] <= in_pc;
      tgt_q[wr_ptr] <= in_tgt;
    end
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (enq && hit_slot[i]) tgt_q[i] <= in_tgt;
  end
endmodule

// File: tb/tb_bpu_update_sched.sv
// tb_bpu_update_sched: directed table, multi-cycle sequences and a queue-based random model for bpu_update_sched.
module tb_bpu_update_sched;
  logic clk = 0, reset;
  logic ex_v, mis_v, flush_all, probe_hit, wr_ready;
  logic [31:0] ex_pc, ex_tgt, mis_pc, mis_tgt;
  logic [2:0] probe_idx, victim_idx;
  logic ex_rdy, mis_rdy, wr_en, wr_valid, busy;
  logic [31:0] probe_pc, wr_pc, wr_tgt;
  logic [2:0] wr_idx;
  int checks = 0, failures = 0;

  bpu_update_sched dut (
    .clk(clk), .reset(reset),
    .ex_upd_valid(ex_v), .ex_upd_pc(ex_pc), .ex_upd_target(ex_tgt), .ex_upd_ready(ex_rdy),
    .mis_upd_valid(mis_v), .mis_upd_pc(mis_pc), .mis_upd_target(mis_tgt), .mis_upd_ready(mis_rdy),
    .flush_all(flush_all), .probe_pc(probe_pc), .probe_hit(probe_hit), .probe_idx(probe_idx),
    .victim_idx(victim_idx), .btb_wr_ready(wr_ready), .btb_wr_en(wr_en), .btb_wr_idx(wr_idx),
    .btb_wr_valid(wr_valid), .btb_wr_pc(wr_pc), .btb_wr_target(wr_tgt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    ex_v = 0; mis_v = 0; flush_all = 0; probe_hit = 0;
    ex_pc = 0; ex_tgt = 0; mis_pc = 0; mis_tgt = 0; probe_idx = 0; victim_idx = 0;
  endtask

  typedef struct {
    logic mv; logic [31:0] mpc, mtgt;
    logic ev; logic [31:0] epc, etgt;
    logic hit; logic [2:0] pidx, vic;
    logic x_mr, x_er, x_en; logic [2:0] x_idx; logic [31:0] x_pc, x_tgt; logic x_busy;
  } vec_t;
  vec_t tbl[6];

  typedef struct {logic [31:0] pc, tgt;} ent_t;
  ent_t q[$];
  bit flushing, pop, acc, e_en, e_mr, e_er;
  int walk, m;
  logic [31:0] rpc, rtgt;

  initial begin
    tbl[0] = '{0, 0, 0, 1, 32'hBFC00010, 32'hBFC00100, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 3, 32'hBFC00010, 32'hBFC00100, 1};
    tbl[2] = '{1, 32'h100, 32'h200, 1, 32'h300, 32'h400, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 32'h300, 32'h400, 1, 5, 2, 1, 1, 1, 5, 32'h100, 32'h200, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 1, 6, 32'h300, 32'h400, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};

    clr(); wr_ready = 1; reset = 1; mis_v = 1; ex_v = 1;
    @(negedge clk); #1;
    chk("rst_mis_rdy", mis_rdy, 0); chk("rst_ex_rdy", ex_rdy, 0);
    chk("rst_wr_en", wr_en, 0); chk("rst_busy", busy, 0); chk("rst_probe_pc", probe_pc, 0);
    @(negedge clk); reset = 0; clr();

    // table: tests 1, 2 and 4
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mis_v = tbl[i].mv; mis_pc = tbl[i].mpc; mis_tgt = tbl[i].mtgt;
      ex_v = tbl[i].ev; ex_pc = tbl[i].epc; ex_tgt = tbl[i].etgt;
      probe_hit = tbl[i].hit; probe_idx = tbl[i].pidx; victim_idx = tbl[i].vic;
      #1;
      chk($sformatf("tbl%0d_mis_rdy", i), mis_rdy, tbl[i].x_mr);
      chk($sformatf("tbl%0d_ex_rdy", i), ex_rdy, tbl[i].x_er);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].x_en);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
      if (tbl[i].x_en) begin
        chk($sformatf("tbl%0d_wr_valid", i), wr_valid, 1);
        chk($sformatf("tbl%0d_wr_idx", i), wr_idx, tbl[i].x_idx);
        chk($sformatf("tbl%0d_wr_pc", i), wr_pc, tbl[i].x_pc);
        chk($sformatf("tbl%0d_wr_tgt", i), wr_tgt, tbl[i].x_tgt);
      end
    end

    // full FIFO with stalled write port
    clr(); wr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ex_v = 1; ex_pc = 32'h1000 + i; ex_tgt = 32'h2000 + i; #1;
      chk($sformatf("full_ex_rdy%0d", i), ex_rdy, i < 4);
    end
    chk("full_busy", busy, 1);
    ex_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_ready = 1; #1;
      chk($sformatf("drain_en%0d", i), wr_en, 1);
      chk($sformatf("drain_pc%0d", i), wr_pc, 32'h1000 + i);
      chk($sformatf("drain_tgt%0d", i), wr_tgt, 32'h2000 + i);
    end
    @(negedge clk); #1;
    chk("drain_done_en", wr_en, 0); chk("drain_done_busy", busy, 0);

    // flush walk with three queued entries
    wr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ex_v = 1; ex_pc = 32'h50 + i; ex_tgt = 32'h60;
    end
    @(negedge clk); ex_v = 0; flush_all = 1; mis_v = 1; #1;
    chk("flush_cycle_en", wr_en, 0); chk("flush_cycle_mis_rdy", mis_rdy, 0);
    @(negedge clk); flush_all = 0; wr_ready = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("walk_en%0d", k), wr_en, 1); chk($sformatf("walk_valid%0d", k), wr_valid, 0);
      chk($sformatf("walk_idx%0d", k), wr_idx, k); chk($sformatf("walk_mis_rdy%0d", k), mis_rdy, 0);
      chk($sformatf("walk_pc%0d", k), wr_pc, 0);
      @(negedge clk);
      if (k == 7) mis_v = 0;
    end
    #1; chk("walk_end_en", wr_en, 0); chk("walk_end_busy", busy, 0);

    // flush restarted mid-walk
    @(negedge clk); flush_all = 1;
    @(negedge clk); flush_all = 0;
    for (int k = 0; k < 3; k++) begin
      #1; chk($sformatf("rwalk_idx%0d", k), wr_idx, k);
      @(negedge clk);
    end
    flush_all = 1; #1; chk("rwalk_flush_en", wr_en, 0);
    @(negedge clk); flush_all = 0;
    for (int k = 0; k < 8; k++) begin
      #1; chk($sformatf("rwalk2_en%0d", k), wr_en, 1); chk($sformatf("rwalk2_idx%0d", k), wr_idx, k);
      @(negedge clk);
    end
    #1; chk("rwalk_end_busy", busy, 0);

    // duplicate pc while stalled
    @(negedge clk); wr_ready = 0; ex_v = 1; ex_pc = 32'h40; ex_tgt = 32'hA0;
    @(negedge clk); ex_tgt = 32'hB0;
    @(negedge clk); ex_v = 0; wr_ready = 1; #1;
    chk("dup_en0", wr_en, 1); chk("dup_pc0", wr_pc, 32'h40);
`ifdef BPU_UPD_COALESCE_EN
    chk("dup_tgt0", wr_tgt, 32'hB0);
    @(negedge clk); #1; chk("dup_en1", wr_en, 0);
`else
    chk("dup_tgt0", wr_tgt, 32'hA0);
    @(negedge clk); #1; chk("dup_en1", wr_en, 1); chk("dup_tgt1", wr_tgt, 32'hB0);
    @(negedge clk); #1; chk("dup_en2", wr_en, 0);
`endif
    chk("dup_busy", busy, 0);

    // random traffic against a queue model
    clr(); reset = 1; @(negedge clk); reset = 0;
    q.delete(); flushing = 0; walk = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mis_v = ($urandom_range(2) == 0); ex_v = ($urandom_range(1) == 0);
      mis_pc = 32'h40 + 4 * $urandom_range(4); ex_pc = 32'h40 + 4 * $urandom_range(4);
      mis_tgt = $urandom; ex_tgt = $urandom;
      flush_all = ($urandom_range(39) == 0); wr_ready = ($urandom_range(3) != 0);
      probe_hit = $urandom_range(1); probe_idx = 3'($urandom); victim_idx = 3'($urandom);
      #1;
      e_mr = !flushing && !flush_all && q.size() < 4;
      e_er = e_mr && !mis_v;
      e_en = !flush_all && (flushing || q.size() > 0);
      chk("rnd_mis_rdy", mis_rdy, e_mr); chk("rnd_ex_rdy", ex_rdy, e_er);
      chk("rnd_wr_en", wr_en, e_en); chk("rnd_busy", busy, q.size() > 0 || flushing);
      if (q.size() > 0) chk("rnd_probe_pc", probe_pc, q[0].pc);
      if (e_en && flushing) begin
        chk("rnd_walk_valid", wr_valid, 0); chk("rnd_walk_idx", wr_idx, walk);
      end else if (e_en) begin
        chk("rnd_valid", wr_valid, 1); chk("rnd_pc", wr_pc, q[0].pc); chk("rnd_tgt", wr_tgt, q[0].tgt);
        chk("rnd_idx", wr_idx, probe_hit ? probe_idx : victim_idx);
      end
      if (flush_all) begin
        q.delete(); flushing = 1; walk = 0;
      end else if (flushing) begin
        if (wr_ready) walk++;
        if (walk == 8) begin flushing = 0; walk = 0; end
      end else begin
        pop = e_en && wr_ready;
        acc = e_mr && (mis_v || ex_v);
        rpc = mis_v ? mis_pc : ex_pc; rtgt = mis_v ? mis_tgt : ex_tgt;
        if (acc) begin
          m = -1;
`ifdef BPU_UPD_COALESCE_EN
          for (int i = pop ? 1 : 0; i < q.size(); i++) if (q[i].pc == rpc) m = i;
`endif
          if (m >= 0) q[m].tgt = rtgt;
          else q.push_back('{rpc, rtgt});
        end
        if (pop) void'(q.pop_front());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
